// File: rtl/ripple_mon_pkg.sv
// Shared types and default widths for the ripple counter monitor.
package ripple_mon_pkg;

  localparam int unsigned DEF_CNT_W         = 4;
  localparam int unsigned DEF_EXT_W         = 12;
  localparam int unsigned DEF_STABLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PENDING
  } mon_state_t;

endpackage

// File: rtl/ripple_sync_filter.sv
// Two-flop synchroniser plus settle filter for the raw ripple count.
// o_accept is high in the cycle before o_cnt_lo takes o_cnt_new.
module ripple_sync_filter
  import ripple_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CNT_W-1:0] i_q,
  output logic [CNT_W-1:0] o_cnt_lo,
  output logic [CNT_W-1:0] o_cnt_new,
  output logic             o_accept
);

  localparam int unsigned          StabW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [StabW-1:0]     StabMax = StabW'(STABLE_CYCLES);

  logic [CNT_W-1:0] r_s1;
  logic [CNT_W-1:0] r_s2;
  logic [CNT_W-1:0] r_s2_prev;
  logic [CNT_W-1:0] r_cnt_lo;
  logic [StabW-1:0] r_stab;
  logic [StabW-1:0] w_stab_nxt;
  logic             w_accept;

  // Run length of identical synchronised samples, saturating at StabMax.
  always_comb begin
    w_stab_nxt = '0;
    if (r_s2 == r_s2_prev) begin
      w_stab_nxt = (r_stab == StabMax) ? r_stab : r_stab + 1'b1;
    end
  end

  assign w_accept = (w_stab_nxt == StabMax) && (r_s2 != r_cnt_lo);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s2_prev <= '0;
      r_stab    <= '0;
      r_cnt_lo  <= '0;
    end else begin
      r_s1      <= i_q;
      r_s2      <= r_s1;
      r_s2_prev <= r_s2;
      r_stab    <= w_stab_nxt;
      if (w_accept) begin
        r_cnt_lo <= r_s2;
      end
    end
  end

  assign o_cnt_lo  = r_cnt_lo;
  assign o_cnt_new = r_s2;
  assign o_accept  = w_accept;

endmodule

// File: rtl/ripple_count_monitor.sv
// Extends a settled ripple count with a wrap counter and raises threshold
// events to a consumer over a valid/ready handshake.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned EXT_W         = DEF_EXT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       q_in,
  input  logic                   enable,
  input  logic [CNT_W+EXT_W-1:0] thresh,
  output logic [CNT_W+EXT_W-1:0] full_count,
  output logic                   wrap_pulse,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CNT_W+EXT_W-1:0] evt_count,
  output logic                   overrun
);

  localparam int unsigned FullW = CNT_W + EXT_W;

  logic [CNT_W-1:0] w_cnt_lo;
  logic [CNT_W-1:0] w_cnt_new;
  logic             w_accept;
  logic             w_crossing;

  logic [EXT_W-1:0] r_ext;
  logic             r_wrap;
  logic             r_acc;
  logic [FullW-1:0] r_prev_full;
  mon_state_t       r_state;
  logic             r_evt_valid;
  logic [FullW-1:0] r_evt_count;
  logic             r_overrun;

  ripple_sync_filter #(
    .CNT_W        (CNT_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_q      (q_in),
    .o_cnt_lo (w_cnt_lo),
    .o_cnt_new(w_cnt_new),
    .o_accept (w_accept)
  );

  assign full_count = {r_ext, w_cnt_lo};

  // A decrease between accepted values is taken as exactly one wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext       <= '0;
      r_wrap      <= 1'b0;
      r_acc       <= 1'b0;
      r_prev_full <= '0;
    end else begin
      r_wrap <= 1'b0;
      r_acc  <= w_accept;
      if (w_accept) begin
        r_prev_full <= full_count;
        if (w_cnt_new < w_cnt_lo) begin
          r_ext  <= r_ext + 1'b1;
          r_wrap <= 1'b1;
        end
      end
    end
  end

  assign w_crossing = r_acc && (r_prev_full < thresh) && (full_count >= thresh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_evt_valid <= 1'b0;
      r_evt_count <= '0;
      r_overrun   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (enable) r_state <= ARMED;
        end
        ARMED: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (w_crossing) begin
            r_state     <= PENDING;
            r_evt_valid <= 1'b1;
            r_evt_count <= full_count;
          end
        end
        PENDING: begin
          // Crossings while an event is outstanding are dropped and flagged.
          if (w_crossing) r_overrun <= 1'b1;
          if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
            r_state     <= enable ? ARMED : IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_evt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign wrap_pulse = r_wrap;
  assign evt_valid  = r_evt_valid;
  assign evt_count  = r_evt_count;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Self-checking bench: full_count changes are scored against a queue filled
// by a reference model as q_in steps are driven.
module tb_ripple_count_monitor;

  logic        clk;
  logic        reset;
  logic [3:0]  q_in;
  logic        enable;
  logic [15:0] thresh;
  logic [15:0] full_count;
  logic        wrap_pulse;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_count;
  logic        overrun;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [16:0] exp_q[$];
  logic [11:0] m_ext;
  logic [3:0]  m_lo;
  logic        mon_on;
  logic [15:0] seen;

  ripple_count_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .enable    (enable),
    .thresh    (thresh),
    .full_count(full_count),
    .wrap_pulse(wrap_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: push the expected {wrap, full_count} for each new value.
  task automatic step(input logic [3:0] v);
    logic w;
    if (v != m_lo) begin
      w = (v < m_lo);
      if (w) m_ext = m_ext + 12'd1;
      m_lo = v;
      exp_q.push_back({w, m_ext, m_lo});
    end
    q_in = v;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = '0;
    m_lo  = '0;
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (mon_on && ((full_count != seen) || wrap_pulse)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {15'd0, wrap_pulse, full_count}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_full", {16'd0, full_count}, {16'd0, e[15:0]});
        check("sb_wrap", {31'd0, wrap_pulse}, {31'd0, e[16]});
      end
    end
    seen = full_count;
  end

  initial begin
    reset     = 1'b1;
    q_in      = '0;
    enable    = 1'b0;
    thresh    = '0;
    evt_ready = 1'b0;
    mon_on    = 1'b0;
    model_reset();
    tick(2);
    check("rst_full", {16'd0, full_count}, 32'd0);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_count", {16'd0, evt_count}, 32'd0);
    check("rst_wrap", {31'd0, wrap_pulse}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Reset mid-count
    step(4'd1); tick(6);
    step(4'd2); tick(6);
    q_in = 4'd3;
    tick(1);
    mon_on = 1'b0;
    reset  = 1'b1;
    tick(3);
    check("midrst_full", {16'd0, full_count}, 32'd0);
    check("midrst_wrap", {31'd0, wrap_pulse}, 32'd0);
    check("midrst_valid", {31'd0, evt_valid}, 32'd0);
    model_reset();
    reset  = 1'b0;
    mon_on = 1'b1;
    step(4'd3);
    tick(1);
    check("rel_wrap", {31'd0, wrap_pulse}, 32'd0);
    tick(6);
    check("rel_full", {16'd0, full_count}, 32'h3);

    // Settling latency and glitch rejection
    step(4'd5);
    tick(4);
    check("lat_before", {16'd0, full_count}, 32'h3);
    tick(1);
    check("lat_at4", {16'd0, full_count}, 32'h5);
    q_in = 4'd3;
    tick(1);
    q_in = 4'd5;
    tick(8);
    check("glitch", {16'd0, full_count}, 32'h5);

    // Wrap through 15 -> 0
    step(4'd14); tick(6);
    step(4'd15); tick(6);
    step(4'd0);  tick(6);
    check("wrap_full0", {16'd0, full_count}, 32'h10);
    step(4'd1);  tick(6);
    check("wrap_full1", {16'd0, full_count}, 32'h11);

    // Threshold crossing with consumer stalled
    enable = 1'b1;
    thresh = 16'h0013;
    tick(2);
    step(4'd2); tick(6);
    check("thr_pre_valid", {31'd0, evt_valid}, 32'd0);
    step(4'd3); tick(6);
    check("thr_valid", {31'd0, evt_valid}, 32'd1);
    check("thr_count", {16'd0, evt_count}, 32'h13);
    tick(4);
    check("thr_hold", {31'd0, evt_valid}, 32'd1);

    // Second crossing while pending sets overrun
    thresh = 16'h0020;
    for (int v = 4; v <= 15; v++) begin
      step(4'(v));
      tick(6);
    end
    check("ovr_pre", {31'd0, overrun}, 32'd0);
    step(4'd0); tick(6);
    check("ovr_full", {16'd0, full_count}, 32'h20);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_count", {16'd0, evt_count}, 32'h13);
    check("ovr_valid", {31'd0, evt_valid}, 32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("hs_done", {31'd0, evt_valid}, 32'd0);

    // Enable dropped while pending
    thresh = 16'h0022;
    step(4'd1); tick(6);
    step(4'd2); tick(6);
    check("en_valid", {31'd0, evt_valid}, 32'd1);
    check("en_count", {16'd0, evt_count}, 32'h22);
    enable = 1'b0;
    tick(5);
    check("en_held", {31'd0, evt_valid}, 32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("en_hs", {31'd0, evt_valid}, 32'd0);
    thresh = 16'h0023;
    step(4'd3); tick(6);
    check("idle_noevt", {31'd0, evt_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset while pending
    enable = 1'b1;
    tick(2);
    thresh = 16'h0024;
    step(4'd4); tick(6);
    check("rp_valid", {31'd0, evt_valid}, 32'd1);
    check("sb_drained", exp_q.size(), 32'd0);
    mon_on = 1'b0;
    reset  = 1'b1;
    tick(1);
    check("rp_drop", {31'd0, evt_valid}, 32'd0);
    check("rp_overrun", {31'd0, overrun}, 32'd0);
    check("rp_full", {16'd0, full_count}, 32'd0);
    check("rp_count", {16'd0, evt_count}, 32'd0);
    reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
